// File: rtl/io_pkg.sv
// io_pkg: shared word type and default depth for the CPU-to-host output buffer.
package io_pkg;
   typedef logic [63:0] io_word_t;
   localparam int IO_OUT_DEPTH_DEFAULT = 8;
endpackage

// File: rtl/io_fifo_mem.sv
// io_fifo_mem: FIFO storage, one clocked write port and one combinational read port.
module io_fifo_mem #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/io_out_buffer.sv
// io_out_buffer: in-order FIFO from the CPU output port to the host with sticky overflow.
// Define IO_OUT_BUFFER_BYPASS_EN for a zero-latency path when the FIFO is empty.
module io_out_buffer
   import io_pkg::*;
#(
   parameter int DEPTH = IO_OUT_DEPTH_DEFAULT,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     out_signal,
   input  logic [WIDTH-1:0]         out_data,
   output logic                     host_valid,
   output logic [WIDTH-1:0]         host_data,
   input  logic                     host_ready,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem_data;
   logic             empty, push, pop, bypass;
   assign empty = count == '0;
   assign full  = count == CW'(DEPTH);
`ifdef IO_OUT_BUFFER_BYPASS_EN
   // An empty FIFO forwards the CPU word directly; it is stored only if the host stalls.
   assign bypass     = empty & out_signal & host_ready;
   assign host_valid = !empty | out_signal;
   assign host_data  = empty ? out_data : mem_data;
`else
   assign bypass     = 1'b0;
   assign host_valid = !empty;
   assign host_data  = mem_data;
`endif
   assign pop  = host_ready & !empty;
   assign push = out_signal & (!full | pop) & !bypass;
   io_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (push & !reset),
      .waddr (wr_ptr),
      .wdata (out_data),
      .raddr (rd_ptr),
      .rdata (mem_data)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (out_signal & full & !pop) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_io_out_buffer.sv
// tb_io_out_buffer: randomized and directed checks of io_out_buffer against a queue model.
module tb_io_out_buffer;
   import io_pkg::*;
   localparam int DEPTH = 8;
   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           out_signal = 1'b0;
   io_word_t       out_data = '0;
   logic           host_valid;
   io_word_t       host_data;
   logic           host_ready = 1'b0;
   logic           full;
   logic [3:0]     count;
   logic           overflow;
   int             checks = 0;
   int             failures = 0;
   io_word_t       q[$];
   bit             ovf;
   logic           obs_valid, exp_valid, xfer;
   io_word_t       obs_data, exp_data;

   io_out_buffer #(.DEPTH(DEPTH), .WIDTH(64)) dut (
      .clk(clk), .reset(reset), .out_signal(out_signal), .out_data(out_data),
      .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
      .full(full), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      reset = 1'b1; out_signal = 1'b1; out_data = {$urandom, $urandom}; host_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; out_signal = 1'b0; host_ready = 1'b0;
      q.delete(); ovf = 0;
   endtask

   // Drive one cycle, sample outputs mid-cycle, then advance the queue model by FIFO rules.
   task automatic step(input logic os, input io_word_t d, input logic hr);
      bit emp, byp;
      out_signal = os; out_data = d; host_ready = hr;
      @(negedge clk);
      obs_valid = host_valid; obs_data = host_data;
      emp = (q.size() == 0);
`ifdef IO_OUT_BUFFER_BYPASS_EN
      exp_valid = !emp || os;
      exp_data = emp ? d : q[0];
      byp = emp && os && hr;
`else
      exp_valid = !emp;
      exp_data = emp ? '0 : q[0];
      byp = 0;
`endif
      xfer = obs_valid && hr;
      if (hr && !emp) void'(q.pop_front());
      if (os && !byp) begin
         if (q.size() < DEPTH) q.push_back(d);
         else ovf = 1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (host_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", host_valid); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
   endtask

   task automatic test_single();
      do_reset();
      step(1'b1, 64'hA5, 1'b0);
      out_signal = 1'b0;
      #1;
      checks++; if (host_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", host_valid); end
      checks++; if (host_data !== 64'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", host_data); end
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
      step(1'b0, '0, 1'b1);
      checks++; if (!xfer || obs_data !== 64'hA5) begin failures++; $display("FAIL single_pop got=%h exp=a5", obs_data); end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL single_drain got=%0d exp=0", count); end
      host_ready = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, io_word_t'(i), 1'b0);
      checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL ovf_fill got=%b/%0d exp=1/8", full, count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      step(1'b1, 64'h99, 1'b0);
      checks++; if (overflow !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL ovf_drop got=%b/%0d exp=1/8", overflow, count); end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, '0, 1'b1);
         checks++; if (!xfer || obs_data !== io_word_t'(i)) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, obs_data, i); end
      end
      checks++; if (count !== 4'd0 || host_valid !== 1'b0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%0d/%b/%b exp=0/0/1", count, host_valid, overflow); end
   endtask

   task automatic test_full_pushpop();
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, io_word_t'(i), 1'b0);
      step(1'b1, 64'h55, 1'b1);
      checks++; if (obs_data !== 64'h0) begin failures++; $display("FAIL fpp_pop got=%h exp=0", obs_data); end
      checks++; if (count !== 4'd8 || overflow !== 1'b0) begin failures++; $display("FAIL fpp_count got=%0d/%b exp=8/0", count, overflow); end
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b0, '0, 1'b1);
         checks++; if (obs_data !== (i == DEPTH ? 64'h55 : io_word_t'(i))) begin failures++; $display("FAIL fpp_drain%0d got=%h", i, obs_data); end
      end
   endtask

   task automatic test_stream();
      int n = 1;
      int maxc = 0;
      do_reset();
      for (int i = 1; i <= 21; i++) begin
         step(i <= 20, io_word_t'(i), 1'b1);
         if (xfer) begin
            checks++; if (obs_data !== io_word_t'(n)) begin failures++; $display("FAIL stream_word got=%h exp=%h", obs_data, n); end
            n++;
         end
         if (int'(count) > maxc) maxc = int'(count);
      end
      checks++; if (n !== 21) begin failures++; $display("FAIL stream_total got=%0d exp=20", n - 1); end
`ifdef IO_OUT_BUFFER_BYPASS_EN
      checks++; if (maxc !== 0) begin failures++; $display("FAIL stream_maxcount got=%0d exp=0", maxc); end
`else
      checks++; if (maxc > 1) begin failures++; $display("FAIL stream_maxcount got=%0d exp<=1", maxc); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, io_word_t'(i), 1'b0);
      step(1'b1, 64'h77, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
      checks++; if (count !== 4'd3 || overflow !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%b exp=3/1", count, overflow); end
      do_reset();
      checks++; if (count !== 4'd0 || host_valid !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/0", count, host_valid, overflow); end
      step(1'b1, 64'h1, 1'b0);
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL mid_first_push got=%0d exp=1", count); end
   endtask

   task automatic test_bypass();
      do_reset();
      out_signal = 1'b1; out_data = 64'h1234; host_ready = 1'b1;
      #1;
`ifdef IO_OUT_BUFFER_BYPASS_EN
      checks++; if (host_valid !== 1'b1 || host_data !== 64'h1234) begin failures++; $display("FAIL bypass_comb got=%b/%h exp=1/1234", host_valid, host_data); end
      @(posedge clk); #1;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
      checks++; if (host_valid !== 1'b0) begin failures++; $display("FAIL nobypass_comb got=%b exp=0", host_valid); end
      @(posedge clk); #1;
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL nobypass_count got=%0d exp=1", count); end
`endif
      out_signal = 1'b0; host_ready = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
         checks++; if (obs_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid%0d got=%b exp=%b", i, obs_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (obs_data !== exp_data) begin failures++; $display("FAIL rnd_data%0d got=%h exp=%h", i, obs_data, exp_data); end
         end
         checks++; if (int'(count) !== q.size()) begin failures++; $display("FAIL rnd_count%0d got=%0d exp=%0d", i, count, q.size()); end
         checks++; if (full !== (q.size() == DEPTH) || overflow !== ovf) begin failures++; $display("FAIL rnd_flags%0d got=%b/%b exp=%b/%b", i, full, overflow, q.size() == DEPTH, ovf); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_pushpop();
      test_stream();
      test_reset_mid();
      test_bypass();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
